// File: rtl/core_irq_pkg.sv
// Shared definitions for the machine external interrupt trap path:
// sequencer state encoding, mcause/mtvec field constants.
package core_irq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SERVICE = 2'd2,
      ST_RETIRE  = 2'd3
   } trap_state_e;

   localparam int          CAUSE_BASE_DEF      = 16;
   localparam int          MTVEC_MODE_VECTORED = 0;
   localparam logic [31:0] IRQ_FLAG_MASK       = 32'h8000_0000;

   // mcause value for an interrupt: flag bit plus 31-bit exception code
   function automatic logic [31:0] mk_cause(input int base, input logic [3:0] id);
      logic [30:0] code;
      code = 31'(base + int'(id));
      return IRQ_FLAG_MASK | {1'b0, code};
   endfunction

endpackage

// File: rtl/irq_arbiter.sv
// Combinational winner select over the masked pending lines, either fixed
// priority (lowest index) or round-robin starting at ptr.
module irq_arbiter
   import core_irq_pkg::*;
#(
   parameter int NUM_IRQ = 6,
   parameter int RR_ARB  = 0
) (
   input  logic [NUM_IRQ-1:0] pending,
   input  logic [3:0]         ptr,
   output logic               valid,
   output logic [3:0]         winner
);

   function automatic int wrap_idx(input logic [3:0] p, input int k);
      int s;
      s = int'(p) + k;
      if (s >= NUM_IRQ) s = s - NUM_IRQ;
      return s;
   endfunction

   always_comb begin
      valid  = |pending;
      winner = '0;
      // walk downward so the closest candidate is assigned last and wins
      for (int k = NUM_IRQ - 1; k >= 0; k--) begin
         if (RR_ARB != 0) begin
            if (pending[wrap_idx(ptr, k)]) winner = 4'(wrap_idx(ptr, k));
         end else begin
            if (pending[k]) winner = 4'(k);
         end
      end
   end

endmodule

// File: rtl/irq_trap_sequencer.sv
// MEI entry/return sequencer: synchronise and mask lines, arbitrate, request
// a trap from the core, strobe MEPC on ack and block nesting until MRET.
module irq_trap_sequencer
   import core_irq_pkg::*;
#(
   parameter int NUM_IRQ     = 6,
   parameter int SYNC_STAGES = 2,
   parameter int RR_ARB      = 0,
   parameter int CAUSE_BASE  = CAUSE_BASE_DEF
) (
   input  logic               i_CLK,
   input  logic               i_RST,
   input  logic [NUM_IRQ-1:0] i_MEI,
   input  logic [NUM_IRQ-1:0] i_MIE,
   input  logic [31:0]        i_MTVEC,
   input  logic [31:0]        i_PC,
   input  logic               i_TRAP_ACK,
   input  logic               i_MRET,
   output logic               o_TRAP_REQ,
   output logic [31:0]        o_TRAP_PC,
   output logic [31:0]        o_CAUSE,
   output logic               o_EPC_WE,
   output logic [31:0]        o_EPC,
   output logic               o_IN_SERVICE,
   output logic [3:0]         o_IRQ_ID
);

   logic [NUM_IRQ-1:0] sync_mei;
   logic [NUM_IRQ-1:0] pending;
   logic               arb_valid;
   logic [3:0]         arb_winner;

   trap_state_e state_q, state_d;
   logic [3:0]  id_q, id_d;
   logic [3:0]  ptr_q, ptr_d;

   logic [31:0] cause_val;
   logic [31:0] vec_base;
   logic        unused_mtvec_b1;

   genvar g;
   generate
      for (g = 0; g < NUM_IRQ; g++) begin : g_sync
         logic [SYNC_STAGES-1:0] sr;
         always_ff @(posedge i_CLK) begin
            if (i_RST) sr <= '0;
            else       sr <= (sr << 1) | SYNC_STAGES'(i_MEI[g]);
         end
         assign sync_mei[g] = sr[SYNC_STAGES-1];
      end
   endgenerate

   assign pending = sync_mei & i_MIE;

   irq_arbiter #(
      .NUM_IRQ (NUM_IRQ),
      .RR_ARB  (RR_ARB)
   ) u_arb (
      .pending (pending),
      .ptr     (ptr_q),
      .valid   (arb_valid),
      .winner  (arb_winner)
   );

   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         state_q <= ST_IDLE;
         id_q    <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
         ptr_q   <= ptr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      ptr_d   = ptr_q;
      case (state_q)
         ST_IDLE: begin
            if (arb_valid) begin
               state_d = ST_REQ;
               id_d    = arb_winner;
            end
         end
         ST_REQ: begin
            // held regardless of the source dropping; only ack releases it
            if (i_TRAP_ACK) begin
               state_d = ST_SERVICE;
               ptr_d   = (id_q == 4'(NUM_IRQ - 1)) ? 4'd0 : id_q + 4'd1;
            end
         end
         ST_SERVICE: begin
            if (i_MRET) state_d = ST_RETIRE;
         end
         ST_RETIRE: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   assign cause_val       = mk_cause(CAUSE_BASE, id_q);
   assign vec_base        = {i_MTVEC[31:2], 2'b00};
   assign unused_mtvec_b1 = i_MTVEC[1];

   always_comb begin
      o_TRAP_REQ   = 1'b0;
      o_TRAP_PC    = '0;
      o_CAUSE      = '0;
      o_EPC_WE     = 1'b0;
      o_EPC        = '0;
      o_IN_SERVICE = 1'b0;
      o_IRQ_ID     = '0;
      case (state_q)
         ST_REQ: begin
            o_TRAP_REQ = 1'b1;
            o_CAUSE    = cause_val;
            o_IRQ_ID   = id_q;
            // vectored offset is 4*code; the code field sits in bits 30:0
            o_TRAP_PC  = i_MTVEC[MTVEC_MODE_VECTORED]
                         ? vec_base + {cause_val[29:0], 2'b00}
                         : vec_base;
            if (i_TRAP_ACK) begin
               o_EPC_WE = 1'b1;
               o_EPC    = i_PC;
            end
         end
         ST_SERVICE: begin
            o_IN_SERVICE = 1'b1;
            o_IRQ_ID     = id_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_irq_trap_sequencer.sv
// Scoreboard bench: fixed-priority and round-robin instances share stimulus;
// expected trap records are queued per instance and popped on each MEPC strobe.
module tb_irq_trap_sequencer;

   typedef struct {
      logic [31:0] tpc;
      logic [31:0] cause;
      logic [31:0] epc;
      logic [3:0]  id;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [5:0]  mei = '0;
   logic [5:0]  mie = 6'h3F;
   logic [31:0] mtvec = 32'h100;
   logic [31:0] pc = '0;
   logic        ack = 1'b0;
   logic        mret = 1'b0;

   logic        a_req, a_we, a_svc, b_req, b_we, b_svc;
   logic [31:0] a_tpc, a_cause, a_epc, b_tpc, b_cause, b_epc;
   logic [3:0]  a_id, b_id;

   exp_t qa[$];
   exp_t qb[$];
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   irq_trap_sequencer #(.NUM_IRQ(6), .SYNC_STAGES(2), .RR_ARB(0), .CAUSE_BASE(16)) u_fix (
      .i_CLK(clk), .i_RST(rst), .i_MEI(mei), .i_MIE(mie), .i_MTVEC(mtvec), .i_PC(pc),
      .i_TRAP_ACK(ack), .i_MRET(mret), .o_TRAP_REQ(a_req), .o_TRAP_PC(a_tpc),
      .o_CAUSE(a_cause), .o_EPC_WE(a_we), .o_EPC(a_epc), .o_IN_SERVICE(a_svc),
      .o_IRQ_ID(a_id));

   irq_trap_sequencer #(.NUM_IRQ(6), .SYNC_STAGES(2), .RR_ARB(1), .CAUSE_BASE(16)) u_rr (
      .i_CLK(clk), .i_RST(rst), .i_MEI(mei), .i_MIE(mie), .i_MTVEC(mtvec), .i_PC(pc),
      .i_TRAP_ACK(ack), .i_MRET(mret), .o_TRAP_REQ(b_req), .o_TRAP_PC(b_tpc),
      .o_CAUSE(b_cause), .o_EPC_WE(b_we), .o_EPC(b_epc), .o_IN_SERVICE(b_svc),
      .o_IRQ_ID(b_id));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // monitors: each MEPC strobe must match the oldest queued trap record
   always @(negedge clk) begin
      #2;
      if (a_we === 1'b1) begin
         if (qa.size() == 0) chk("fix_unexpected_epc_we", 32'(a_we), 32'd0);
         else begin
            exp_t e;
            e = qa.pop_front();
            chk("fix_trap_pc", a_tpc, e.tpc);
            chk("fix_cause", a_cause, e.cause);
            chk("fix_epc", a_epc, e.epc);
            chk("fix_irq_id", 32'(a_id), 32'(e.id));
            chk("fix_req_at_ack", 32'(a_req), 32'd1);
         end
      end
   end

   always @(negedge clk) begin
      #2;
      if (b_we === 1'b1) begin
         if (qb.size() == 0) chk("rr_unexpected_epc_we", 32'(b_we), 32'd0);
         else begin
            exp_t e;
            e = qb.pop_front();
            chk("rr_trap_pc", b_tpc, e.tpc);
            chk("rr_cause", b_cause, e.cause);
            chk("rr_epc", b_epc, e.epc);
            chk("rr_irq_id", 32'(b_id), 32'(e.id));
            chk("rr_req_at_ack", 32'(b_req), 32'd1);
         end
      end
   end

   task automatic wait_req(input string name);
      int n;
      n = 0;
      while (!(a_req && b_req) && n < 12) begin
         @(negedge clk);
         n++;
      end
      chk(name, 32'(a_req && b_req), 32'd1);
   endtask

   task automatic ack_trap(input logic [31:0] epc, input logic [31:0] tpc,
                           input logic [3:0] ida, input logic [31:0] ca,
                           input logic [3:0] idb, input logic [31:0] cb);
      exp_t e;
      e.tpc = tpc; e.epc = epc; e.id = ida; e.cause = ca;
      qa.push_back(e);
      e.id = idb; e.cause = cb;
      qb.push_back(e);
      pc  = epc;
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      chk("in_service_after_ack", 32'({a_svc, b_svc}), 32'h3);
      chk("req_drop_after_ack", 32'({a_req, b_req}), 32'h0);
   endtask

   task automatic retire();
      mret = 1'b1;
      @(negedge clk);
      mret = 1'b0;
      chk("retire_no_service", 32'({a_svc, b_svc}), 32'h0);
      chk("retire_no_req", 32'({a_req, b_req}), 32'h0);
      @(negedge clk);
   endtask

   task automatic chk_zero(input string name);
      chk({name, "_fix"}, 32'({a_req, a_we, a_svc, a_id}) | a_tpc | a_cause | a_epc, 32'd0);
      chk({name, "_rr"},  32'({b_req, b_we, b_svc, b_id}) | b_tpc | b_cause | b_epc, 32'd0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk_zero("reset_outputs");
      rst = 1'b0;

      // direct mode, exact entry latency
      @(negedge clk);
      mei = 6'b000100;
      repeat (2) @(negedge clk);
      chk("direct_req_not_early", 32'({a_req, b_req}), 32'h0);
      @(negedge clk);
      chk("direct_req_latency", 32'({a_req, b_req}), 32'h3);
      ack_trap(32'h40, 32'h100, 4'd2, 32'h8000_0012, 4'd2, 32'h8000_0012);
      mei = '0;
      retire();

      // vectored mode: 0x100 + 4*21
      mtvec = 32'h101;
      mei = 6'b100000;
      wait_req("vectored_req");
      ack_trap(32'h80, 32'h154, 4'd5, 32'h8000_0015, 4'd5, 32'h8000_0015);
      mei = '0;
      mtvec = 32'h100;
      retire();

      // lines 1 and 4 held: fixed takes 1 twice, round-robin takes 1 then 4
      mei = 6'b010010;
      wait_req("prio_req_first");
      ack_trap(32'h200, 32'h100, 4'd1, 32'h8000_0011, 4'd1, 32'h8000_0011);
      retire();
      wait_req("prio_req_second");
      ack_trap(32'h204, 32'h100, 4'd1, 32'h8000_0011, 4'd4, 32'h8000_0014);
      mei = '0;
      retire();

      // no nesting while in service
      mei = 6'b000100;
      wait_req("nest_req");
      ack_trap(32'h300, 32'h100, 4'd2, 32'h8000_0012, 4'd2, 32'h8000_0012);
      mei = 6'b000001;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("nest_blocked_req", 32'({a_req, b_req}), 32'h0);
      end
      retire();
      chk("nest_idle_cycle", 32'({a_req, b_req}), 32'h0);
      @(negedge clk);
      chk("nest_req_after_retire", 32'({a_req, b_req}), 32'h3);
      chk("nest_id", 32'({a_id, b_id}), 32'h00);
      ack_trap(32'h304, 32'h100, 4'd0, 32'h8000_0010, 4'd0, 32'h8000_0010);
      mei = '0;
      retire();

      // request stays up after source drops and is masked
      mei = 6'b001000;
      wait_req("sticky_req");
      mei = '0;
      mie = 6'h37;
      repeat (4) @(negedge clk);
      chk("sticky_req_held", 32'({a_req, b_req}), 32'h3);
      chk("sticky_id_held", 32'({a_id, b_id}), 32'h33);
      ack_trap(32'h400, 32'h100, 4'd3, 32'h8000_0013, 4'd3, 32'h8000_0013);
      mie = 6'h3F;
      retire();

      // reset while requesting
      mei = 6'b000010;
      wait_req("rst_req_req");
      rst = 1'b1;
      mei = '0;
      @(negedge clk);
      rst = 1'b0;
      chk_zero("rst_in_req");
      ack  = 1'b1;
      mret = 1'b1;
      #1;
      chk("spurious_ack_no_we", 32'({a_we, b_we}), 32'h0);
      @(negedge clk);
      ack  = 1'b0;
      mret = 1'b0;
      chk("spurious_stay_idle", 32'({a_req, b_req, a_svc, b_svc}), 32'h0);

      // reset while in service
      mei = 6'b000010;
      wait_req("rst_svc_req");
      ack_trap(32'h500, 32'h100, 4'd1, 32'h8000_0011, 4'd1, 32'h8000_0011);
      mei = '0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_zero("rst_in_service");
      mret = 1'b1;
      @(negedge clk);
      mret = 1'b0;
      chk("post_rst_mret_idle", 32'({a_req, b_req, a_svc, b_svc}), 32'h0);
      repeat (2) @(negedge clk);
      chk_zero("post_rst_quiet");

      chk("fix_queue_drained", 32'(qa.size()), 32'd0);
      chk("rr_queue_drained", 32'(qb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/irq_trap_sequencer.md
Name: irq_trap_sequencer

Overview:
- Sequences machine external interrupt entry and return for the single-issue core.
- Synchronises the MEI lines, masks them with MIE, and arbitrates between pending sources.
- Raises a trap request to the core fetch/exec control and hands back the trap target PC, the cause code and the MEPC write strobe.
- Blocks nesting until the core executes MRET. Sits between the interrupt pins, the CSR file (MIE/MTVEC/MEPC) and the core state machine.

Parameters:
- NUM_IRQ, 6: number of external interrupt lines (1..16).
- SYNC_STAGES, 2: synchroniser flops per MEI line (>=1).
- RR_ARB, 0: 0 = fixed priority, lowest index wins; 1 = round-robin.
- CAUSE_BASE, 16: mcause exception code for line 0; line n reports CAUSE_BASE+n.

Ports:
- i_CLK  in  1  core clock
- i_RST  in  1  synchronous, active-high reset
- i_MEI  in  NUM_IRQ  asynchronous level interrupt lines
- i_MIE  in  NUM_IRQ  enable mask from CSR MIE[NUM_IRQ-1:0]
- i_MTVEC  in  32  trap vector CSR; bit0 = 1 selects vectored mode
- i_PC  in  32  PC of the instruction at the current boundary
- i_TRAP_ACK  in  1  core accepts the trap at an instruction boundary
- i_MRET  in  1  one-cycle pulse when the core retires MRET
- o_TRAP_REQ  out  1  trap request to the core
- o_TRAP_PC  out  32  redirect target, valid while o_TRAP_REQ is high
- o_CAUSE  out  32  {1'b1, 31'(CAUSE_BASE+id)}, valid while o_TRAP_REQ is high
- o_EPC_WE  out  1  one-cycle MEPC/MCAUSE write strobe
- o_EPC  out  32  value to write into MEPC
- o_IN_SERVICE  out  1  a handler is active; no new trap is raised
- o_IRQ_ID  out  4  id of the line being requested or serviced

Behaviour:
- Reset (i_RST sampled high at a clock edge):
  - State goes to IDLE; synchronisers, RR pointer and all outputs go to 0.
  - Reset applied mid-REQ or mid-SERVICE abandons the trap silently; no o_EPC_WE is issued.
- Masking: pending = sync(i_MEI) & i_MIE, evaluated every cycle. Latency from an i_MEI edge to pending is SYNC_STAGES cycles.
- States: IDLE, REQ, SERVICE, RETIRE.
- IDLE:
  - If |pending, register the arbitration winner id and move to REQ on the next edge.
  - Trap-entry latency: o_TRAP_REQ rises 1 cycle after pending is seen.
- Arbitration:
  - Fixed priority: the lowest set index wins.
  - Round-robin: the first set index at or after ptr, wrapping modulo NUM_IRQ. ptr <= (winner+1) mod NUM_IRQ on ack only.
- REQ:
  - o_TRAP_REQ=1. o_TRAP_PC, o_CAUSE and o_IRQ_ID hold stable until ack.
  - The request is not withdrawn if the source deasserts or is masked.
  - Target PC: base = {i_MTVEC[31:2],2'b00}. Direct mode: o_TRAP_PC = base. Vectored mode: o_TRAP_PC = base + 4*(CAUSE_BASE+id), 32-bit wrap.
  - On i_TRAP_ACK: o_EPC_WE=1 and o_EPC=i_PC in that same cycle (combinational). State moves to SERVICE and o_TRAP_REQ drops on the next edge.
- SERVICE:
  - o_IN_SERVICE=1 and o_IRQ_ID is held. Pending lines are ignored (no nesting).
  - i_MRET moves the state to RETIRE.
- RETIRE:
  - Lasts one cycle with o_IN_SERVICE=0 and no request, so the handler's source clear propagates.
  - Then IDLE; re-arbitration happens in IDLE.
- Ignored inputs:
  - i_MRET in IDLE/REQ/RETIRE has no effect.
  - i_TRAP_ACK outside REQ has no effect.
  - i_MRET and i_TRAP_ACK arriving together are only possible in states where one of them is ignored.
- Interrupts are always enabled globally. The core gates i_TRAP_ACK if it needs a global disable.

Decomposition:
- Shared package core_irq_pkg:
  - state encoding (IDLE=0, REQ=1, SERVICE=2, RETIRE=3)
  - CAUSE_BASE default
  - MTVEC_MODE_VECTORED bit index
  - interrupt-flag mask 32'h8000_0000
- Sub-module irq_arbiter: combinational winner/valid from pending, ptr and RR_ARB. The ptr register stays in the top.
- The synchroniser is a generate loop in the top, not a separate module.

Test Plan:
- Direct trap: MIE=6'h3F, MTVEC=0x100, MEI[2] raised, ack at PC=0x40. Require:
  - o_TRAP_REQ high SYNC_STAGES+1 cycles after the edge
  - o_TRAP_PC=0x100, o_CAUSE=0x80000012
  - o_EPC_WE pulse with o_EPC=0x40, then o_IN_SERVICE=1
- Vectored trap: MTVEC=0x101, MEI[5] raised. Require o_TRAP_PC = 0x100 + 4*21 = 0x154.
- Priority/round-robin with MEI[1] and MEI[4] held:
  - RR_ARB=0: id 1 is taken, then after MRET+RETIRE, id 1 again.
  - RR_ARB=1: id 1 is taken, then id 4.
- No nesting: in SERVICE, raise MEI[0]. Require no o_TRAP_REQ until MRET. MRET is followed by a one-cycle RETIRE, then REQ id 0.
- Request stickiness: MEI[3] is dropped and MIE[3] cleared while in REQ. Require o_TRAP_REQ and id 3 held until ack.
- Reset mid-operation: assert i_RST in REQ and again in SERVICE. Require all outputs 0 the next cycle and no o_EPC_WE. A spurious i_MRET or ack afterwards leaves the state in IDLE.
